if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core.
- Sits directly upstream of the decoder.
- Owns the program counter, selects the next PC (sequential, branch, jump, jr), drives the instruction-memory address, and registers the fetched instruction plus PC+4 into the IF/ID pipeline register.
- The decoder consumes the IF/ID outputs.
- Stall and flush inputs come from the hazard unit.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/pc_sel.sv | 33 +++
 rtl/if_stage.sv | 111 +++++++++++
 tb/tb_if_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core package: reset/bubble constants, MIPS opcode/funct encodings,
// the instruction-field view used by fetch and decode, and a PC align helper.
package cpu_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  // Word-align an address by clearing the byte-offset bits.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sel.sv
// Next-PC priority mux: jr > jump > branch > sequential.
// Also reports whether a redirect is taken and whether its target was
// misaligned (low two bits set) before alignment.
module pc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] seq_pc_o,
  output logic [31:0] next_pc_o,
  output logic        redirect_o,
  output logic        misalign_o
);

  logic [31:0] tgt;

  // Select the redirect target by priority and form the next PC.
  always_comb begin
    tgt = branch_target_i;
    if (jr_i)        tgt = jr_target_i;
    else if (jump_i) tgt = jump_target_i;
    seq_pc_o   = pc_i + 32'd4;
    redirect_o = jr_i | jump_i | branch_taken_i;
    misalign_o = redirect_o & (tgt[1:0] != 2'b00);
    next_pc_o  = redirect_o ? align_pc(tgt) : seq_pc_o;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem address and loads
// the IF/ID register (instruction, PC+4, valid).
// Optional perf counters compiled in with `define IF_STAGE_PERF_CNT_EN.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = cpu_pkg::PC_RESET,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
`ifdef IF_STAGE_PERF_CNT_EN
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o,
`endif
  output logic        misalign_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] seq_pc, sel_pc;
  logic        redirect, tgt_misalign;
  logic        bubble, load;

  pc_sel u_pc_sel (
    .pc_i            (pc_q),
    .jr_i            (jr_i),
    .jr_target_i     (jr_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .seq_pc_o        (seq_pc),
    .next_pc_o       (sel_pc),
    .redirect_o      (redirect),
    .misalign_o      (tgt_misalign)
  );

  // Redirect beats stall; a stall alone holds the PC.
  always_comb begin
    pc_d = sel_pc;
    if (!redirect && stall_i) pc_d = pc_q;
  end

  // Flush wins over stall for IF/ID so a held instruction never issues twice.
  assign bubble = redirect | flush_i;
  assign load   = !bubble && !stall_i;

  assign imem_addr_o = pc_q;

  // Program counter and misalign pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= PC_RESET;
      misalign_o <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_o <= tgt_misalign;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_o    <= NOP_INSTR;
      pc_plus4_o <= 32'd0;
      valid_o    <= 1'b0;
    end else if (bubble) begin
      instr_o    <= NOP_INSTR;
      pc_plus4_o <= seq_pc;
      valid_o    <= 1'b0;
    end else if (load) begin
      instr_o    <= imem_data_i;
      pc_plus4_o <= seq_pc;
      valid_o    <= 1'b1;
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  // Saturating fetch/bubble counters; stall-hold cycles count as neither.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (load && fetch_cnt_q != 32'hFFFF_FFFF)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (bubble && bubble_cnt_q != 32'hFFFF_FFFF)
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then randomized
// redirect/stall/flush/reset traffic against a behavioural fetch model.
module tb_if_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0, flush_i = 1'b0;
  logic        branch_taken_i = 1'b0, jump_i = 1'b0, jr_i = 1'b0;
  logic [31:0] branch_target_i = '0, jump_target_i = '0, jr_target_i = '0;
  logic [31:0] imem_addr_o, imem_data_i, instr_o, pc_plus4_o;
  logic        valid_o, misalign_o;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_cnt_o, bubble_cnt_o;
`endif

  if_stage dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .jr_i            (jr_i),
    .jr_target_i     (jr_target_i),
    .imem_addr_o     (imem_addr_o),
    .imem_data_i     (imem_data_i),
    .instr_o         (instr_o),
    .pc_plus4_o      (pc_plus4_o),
    .valid_o         (valid_o),
`ifdef IF_STAGE_PERF_CNT_EN
    .fetch_cnt_o     (fetch_cnt_o),
    .bubble_cnt_o    (bubble_cnt_o),
`endif
    .misalign_o      (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory: word n holds 32'h2008_0000 + n.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0000 + {2'b00, a[31:2]};
  endfunction
  assign imem_data_i = mem_word(imem_addr_o);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_fcnt, m_bcnt;
  logic        m_valid, m_mis;

  task automatic model_edge();
    logic [31:0] tgt;
    logic        redir;
    if (rst_i) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_mis = 1'b0; m_fcnt = 0; m_bcnt = 0;
      return;
    end
    redir = jr_i || jump_i || branch_taken_i;
    tgt   = jr_i ? jr_target_i : jump_i ? jump_target_i : branch_target_i;
    m_mis = redir && (tgt % 4 != 0);
    if (redir || flush_i) begin
      m_instr = 32'h0; m_valid = 1'b0; m_pc4 = m_pc + 4;
      if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
    end else if (!stall_i) begin
      m_instr = mem_word(m_pc); m_valid = 1'b1; m_pc4 = m_pc + 4;
      if (m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
    end
    if (redir)         m_pc = tgt - (tgt % 4);
    else if (!stall_i) m_pc = m_pc + 4;
  endtask

  // One clock: model follows the edge, then every output is compared.
  task automatic cyc();
    @(posedge clk_i);
    model_edge();
    #1;
    chk("pc",       imem_addr_o, m_pc);
    chk("instr",    instr_o,     m_instr);
    chk("pc_plus4", pc_plus4_o,  m_pc4);
    chk("valid",    {31'b0, valid_o},    {31'b0, m_valid});
    chk("misalign", {31'b0, misalign_o}, {31'b0, m_mis});
`ifdef IF_STAGE_PERF_CNT_EN
    chk("fetch_cnt",  fetch_cnt_o,  m_fcnt);
    chk("bubble_cnt", bubble_cnt_o, m_bcnt);
`endif
  endtask

  task automatic idle();
    rst_i = 0; stall_i = 0; flush_i = 0;
    jr_i = 0; jump_i = 0; branch_taken_i = 0;
  endtask

  initial begin
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mis = 0; m_fcnt = 0; m_bcnt = 0;
    #1;
    // Reset state
    rst_i = 1; cyc(); cyc();
    chk("rst_pc",    imem_addr_o, 32'h0);
    chk("rst_valid", {31'b0, valid_o}, 32'h0);

    // Free run: words 0..1 then stall at pc 8
    idle();
    cyc();
    chk("run0_instr", instr_o, 32'h2008_0000);
    chk("run0_pc4",   pc_plus4_o, 32'd4);
    chk("run0_valid", {31'b0, valid_o}, 32'h1);
    cyc();
    chk("run1_instr", instr_o, 32'h2008_0001);
    stall_i = 1; cyc(); cyc();
    chk("stall_pc",    imem_addr_o, 32'd8);
    chk("stall_instr", instr_o, 32'h2008_0001);
    chk("stall_pc4",   pc_plus4_o, 32'd8);
    stall_i = 0; cyc();
    chk("resume_pc", imem_addr_o, 32'd12);
    cyc();
    chk("run3_pc4", pc_plus4_o, 32'd16);

    // Branch at pc 16 -> 0x40, one bubble
    branch_taken_i = 1; branch_target_i = 32'h40; cyc();
    chk("br_pc",    imem_addr_o, 32'h40);
    chk("br_valid", {31'b0, valid_o}, 32'h0);
    chk("br_instr", instr_o, 32'h0);
    idle(); cyc();
    chk("br_word", instr_o, 32'h2008_0010);

    // Priority jr > jump > branch
    jr_i = 1; jr_target_i = 32'h100; jump_i = 1; jump_target_i = 32'h200;
    branch_taken_i = 1; branch_target_i = 32'h300; cyc();
    chk("prio_pc", imem_addr_o, 32'h100);

    // Misaligned jump target
    idle(); jump_i = 1; jump_target_i = 32'h87; cyc();
    chk("mis_pc",  imem_addr_o, 32'h84);
    chk("mis_set", {31'b0, misalign_o}, 32'h1);
    idle(); cyc();
    chk("mis_clr", {31'b0, misalign_o}, 32'h0);

    // Stall + flush at pc 20, then reset mid-stall
    jump_i = 1; jump_target_i = 32'd20; cyc();
    idle(); stall_i = 1; flush_i = 1; cyc();
    chk("sf_pc",    imem_addr_o, 32'd20);
    chk("sf_valid", {31'b0, valid_o}, 32'h0);
    flush_i = 0; rst_i = 1; cyc();
    chk("rst_mid_pc", imem_addr_o, 32'h0);

    // 32-bit wrap of the sequential PC
    idle(); jump_i = 1; jump_target_i = 32'hFFFF_FFFC; cyc();
    idle(); cyc();
    chk("wrap_pc",  imem_addr_o, 32'h0);
    chk("wrap_pc4", pc_plus4_o, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_i          = ($urandom_range(0, 63) == 0);
      stall_i        = ($urandom_range(0, 3) == 0);
      flush_i        = ($urandom_range(0, 7) == 0);
      branch_taken_i = ($urandom_range(0, 7) == 0);
      jump_i         = ($urandom_range(0, 9) == 0);
      jr_i           = ($urandom_range(0, 11) == 0);
      branch_target_i = $urandom;
      jump_target_i   = $urandom;
      jr_target_i     = $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
